block_framer: RTL and testbench

- Encoder-side counterpart of the overlap-add stage: segments a continuous PCM stream into 50%-overlapped analysis blocks for the forward MDCT.
- Input: 64-bit words of four packed 16-bit PCM samples.
- Each block emitted = previous half-block followed by current half-block.
- Sits between the PCM input interface and the windowing/MDCT stage.

---
 rtl/framer_pkg.sv | 19 +
 rtl/block_framer_if.sv | 39 +++
 rtl/framer_bank.sv | 29 ++
 rtl/block_framer.sv | 170 +++++++++++++++++
 tb/tb_block_framer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/framer_pkg.sv
// Shared types and constants for the block framer.
// The packing here is assumed by block_framer, framer_bank and block_framer_if.
package framer_pkg;

    localparam int SAMPLE_W = 16;
    localparam int LANES    = 4;
    localparam int BUS_W    = SAMPLE_W * LANES;

    // EMIT_ZERO is only reachable when BLOCK_FRAMER_FLUSH_EN is defined.
    typedef enum logic [1:0] {
        FILL,
        EMIT_PREV,
        EMIT_CUR,
        EMIT_ZERO
    } framer_state_t;

    typedef logic [BUS_W-1:0] pcm_word_t;

endpackage

// File: rtl/block_framer_if.sv
// PCM input/output handshake bundle for block_framer.
// The flush/flush_done pair exists only when BLOCK_FRAMER_FLUSH_EN is defined.
interface block_framer_if;
    import framer_pkg::*;

    logic      in_valid;
    logic      in_ready;
    pcm_word_t dataBusIn;
    logic      out_valid;
    logic      out_ready;
    pcm_word_t dataBusOut;
    logic      out_first;
    logic      out_last;
`ifdef BLOCK_FRAMER_FLUSH_EN
    logic      flush;
    logic      flush_done;

    modport master (
        output in_valid, dataBusIn, out_ready, flush,
        input  in_ready, out_valid, dataBusOut, out_first, out_last, flush_done
    );

    modport slave (
        input  in_valid, dataBusIn, out_ready, flush,
        output in_ready, out_valid, dataBusOut, out_first, out_last, flush_done
    );
`else
    modport master (
        output in_valid, dataBusIn, out_ready,
        input  in_ready, out_valid, dataBusOut, out_first, out_last
    );

    modport slave (
        input  in_valid, dataBusIn, out_ready,
        output in_ready, out_valid, dataBusOut, out_first, out_last
    );
`endif

endinterface

// File: rtl/framer_bank.sv
// Two half-block banks: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the framer masks stale data itself.
module framer_bank
    import framer_pkg::*;
#(
    parameter int HALF_WORDS = 4,
    localparam int IDX_W     = $clog2(HALF_WORDS)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  pcm_word_t        wr_data,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output pcm_word_t        rd_data
);

    pcm_word_t mem [2][HALF_WORDS];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/block_framer.sv
// Splits a PCM word stream into 50%-overlapped blocks (previous half, then current half).
// Define BLOCK_FRAMER_FLUSH_EN to add a flush input that emits a zero-padded final block.
module block_framer
    import framer_pkg::*;
#(
    parameter int HALF_WORDS = 4,
    parameter int ZERO_FIRST = 1
) (
    input  logic           clock,
    input  logic           reset,
    block_framer_if.slave  bus
);

    localparam int               IDX_W    = $clog2(HALF_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HALF_WORDS - 1);

    framer_state_t    state, state_n;
    logic             cur, cur_n;
    logic [IDX_W-1:0] wr_idx, wr_n;
    logic [IDX_W-1:0] rd_idx, rd_n;
    logic             prev_valid, pv_n;
    logic             in_acc, out_acc;
    logic             rd_bank;
    pcm_word_t        rd_data;
    pcm_word_t        data_n;
`ifdef BLOCK_FRAMER_FLUSH_EN
    logic             flushing, fl_n;
    logic             done_n;
`endif

    assign in_acc  = bus.in_valid & bus.in_ready;
    assign out_acc = bus.out_valid & bus.out_ready;

    framer_bank #(.HALF_WORDS(HALF_WORDS)) u_bank (
        .clock   (clock),
        .wr_en   (in_acc),
        .wr_bank (cur),
        .wr_idx  (wr_idx),
        .wr_data (bus.dataBusIn),
        .rd_bank (rd_bank),
        .rd_idx  (rd_n),
        .rd_data (rd_data)
    );

    always_comb begin
        state_n = state;
        cur_n   = cur;
        wr_n    = wr_idx;
        rd_n    = rd_idx;
        pv_n    = prev_valid;
`ifdef BLOCK_FRAMER_FLUSH_EN
        fl_n    = flushing;
        done_n  = 1'b0;
`endif
        case (state)
            FILL: begin
                if (in_acc) begin
                    if (wr_idx == LAST_IDX) begin
                        wr_n = '0;
                        if (prev_valid || (ZERO_FIRST != 0)) begin
                            state_n = EMIT_PREV;
                        end else begin
                            cur_n = ~cur;
                            pv_n  = 1'b1;
                        end
                    end else begin
                        wr_n = wr_idx + IDX_W'(1);
                    end
                end
`ifdef BLOCK_FRAMER_FLUSH_EN
                // An accepted word always wins, so a flush can never drop input.
                else if (bus.flush && (wr_idx == '0) && prev_valid) begin
                    state_n = EMIT_PREV;
                    fl_n    = 1'b1;
                end
`endif
            end
            EMIT_PREV: begin
                if (out_acc) begin
                    if (rd_idx == LAST_IDX) begin
                        rd_n    = '0;
                        state_n = EMIT_CUR;
`ifdef BLOCK_FRAMER_FLUSH_EN
                        if (flushing) begin
                            state_n = EMIT_ZERO;
                        end
`endif
                    end else begin
                        rd_n = rd_idx + IDX_W'(1);
                    end
                end
            end
            EMIT_CUR: begin
                if (out_acc) begin
                    if (rd_idx == LAST_IDX) begin
                        rd_n    = '0;
                        cur_n   = ~cur;
                        pv_n    = 1'b1;
                        state_n = FILL;
                    end else begin
                        rd_n = rd_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
`ifdef BLOCK_FRAMER_FLUSH_EN
                if (out_acc) begin
                    if (rd_idx == LAST_IDX) begin
                        rd_n    = '0;
                        pv_n    = 1'b0;
                        fl_n    = 1'b0;
                        done_n  = 1'b1;
                        state_n = FILL;
                    end else begin
                        rd_n = rd_idx + IDX_W'(1);
                    end
                end
`else
                state_n = FILL;
`endif
            end
        endcase
    end

    // Outputs are registered, so the read port looks ahead at the next state and index.
    always_comb begin
        rd_bank = (state_n == EMIT_PREV) ? ~cur_n : cur_n;
        data_n  = '0;
        case (state_n)
            EMIT_PREV: data_n = prev_valid ? rd_data : '0;
            EMIT_CUR:  data_n = rd_data;
            default:   data_n = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= FILL;
            cur            <= 1'b0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            prev_valid     <= 1'b0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_first  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.dataBusOut <= '0;
`ifdef BLOCK_FRAMER_FLUSH_EN
            flushing       <= 1'b0;
            bus.flush_done <= 1'b0;
`endif
        end else begin
            state          <= state_n;
            cur            <= cur_n;
            wr_idx         <= wr_n;
            rd_idx         <= rd_n;
            prev_valid     <= pv_n;
            bus.in_ready   <= (state_n == FILL);
            bus.out_valid  <= (state_n != FILL);
            bus.out_first  <= (state_n == EMIT_PREV) && (rd_n == '0);
            bus.out_last   <= ((state_n == EMIT_CUR) || (state_n == EMIT_ZERO)) && (rd_n == LAST_IDX);
            bus.dataBusOut <= data_n;
`ifdef BLOCK_FRAMER_FLUSH_EN
            flushing       <= fl_n;
            bus.flush_done <= done_n;
`endif
        end
    end

endmodule

// File: tb/tb_block_framer.sv
// Randomized bench for block_framer against a queue-based overlap model.
// Define BLOCK_FRAMER_FLUSH_EN to also exercise the flush path.
module tb_block_framer;
    import framer_pkg::*;

    localparam int HALF = 4;

    typedef struct {
        pcm_word_t data;
        logic      first;
        logic      last;
        logic      flushEnd;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    block_framer_if bus();

    block_framer #(.HALF_WORDS(HALF), .ZERO_FIRST(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    exp_t      expQ[$];
    pcm_word_t halfBuf[$];
    pcm_word_t prevHalf[HALF];
    bit        havePrev = 0;
    int        errors = 0;
    int        checks = 0;
    int        outAccepts = 0;
    int        readyMode = 0;
    bit        gapMode = 0;
    bit        resetPending = 0;
    bit        latencyPending = 0;
    bit        stallPending = 0;
    bit        doneExpected = 0;
    pcm_word_t stallData;
    logic      stallFirst, stallLast;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic pcm_word_t randWord();
        return pcm_word_t'({$urandom(), $urandom()});
    endfunction

    // A block is the previous half (or silence) followed by the newest half.
    function automatic void buildBlock(input bit flushBlock);
        for (int i = 0; i < HALF; i++)
            expQ.push_back(exp_t'{havePrev ? prevHalf[i] : '0, i == 0, 1'b0, 1'b0});
        for (int i = 0; i < HALF; i++)
            expQ.push_back(exp_t'{flushBlock ? '0 : halfBuf[i], 1'b0, i == HALF-1,
                                  flushBlock && (i == HALF-1)});
        if (flushBlock) begin
            havePrev = 0;
        end else begin
            for (int i = 0; i < HALF; i++) prevHalf[i] = halfBuf[i];
            havePrev = 1;
            halfBuf.delete();
        end
    endfunction

    always @(negedge clock) begin
        bit   emitting;
        exp_t e;
        if (resetPending) begin
            checkOutput("rst_out_valid", bus.out_valid, 0);
            checkOutput("rst_out_first", bus.out_first, 0);
            checkOutput("rst_out_last", bus.out_last, 0);
            checkOutput("rst_dataBusOut", bus.dataBusOut, 0);
            checkOutput("rst_in_ready", bus.in_ready, 1);
            resetPending = 0;
        end
        if (latencyPending) begin
            checkOutput("latency_out_valid", bus.out_valid, 1);
            latencyPending = 0;
        end
        if (stallPending) begin
            checkOutput("stall_valid", bus.out_valid, 1);
            checkOutput("stall_data", bus.dataBusOut, stallData);
            checkOutput("stall_first", bus.out_first, stallFirst);
            checkOutput("stall_last", bus.out_last, stallLast);
            stallPending = 0;
        end
`ifdef BLOCK_FRAMER_FLUSH_EN
        checkOutput("flush_done", bus.flush_done, doneExpected);
`endif
        doneExpected = 0;
        if (reset == 1'b0) begin
            expQ.delete();
            halfBuf.delete();
            havePrev = 0;
            latencyPending = 0;
            resetPending = 1;
        end else begin
            emitting = (expQ.size() != 0);
            checkOutput("out_valid", bus.out_valid, emitting);
            checkOutput("in_ready", bus.in_ready, !emitting);
            if (bus.out_valid && bus.out_ready) begin
                outAccepts++;
                if (expQ.size() == 0) begin
                    checkOutput("spurious_out", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("data", bus.dataBusOut, e.data);
                    checkOutput("out_first", bus.out_first, e.first);
                    checkOutput("out_last", bus.out_last, e.last);
                    if (e.flushEnd) doneExpected = 1;
                end
            end else if (bus.out_valid) begin
                stallPending = 1;
                stallData    = bus.dataBusOut;
                stallFirst   = bus.out_first;
                stallLast    = bus.out_last;
            end
            if (bus.in_valid && !emitting) begin
                halfBuf.push_back(bus.dataBusIn);
                if (halfBuf.size() == HALF) begin
                    buildBlock(0);
                    latencyPending = 1;
                end
            end
`ifdef BLOCK_FRAMER_FLUSH_EN
            else if (bus.flush && !emitting && !bus.in_valid && halfBuf.size() == 0 && havePrev) begin
                buildBlock(1);
                latencyPending = 1;
            end
`endif
        end
    end

    // Downstream readiness: 0 = always, 1 = 1,0,0 pattern, 2 = random.
    initial begin
        int cyc = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            case (readyMode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 3 == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic applyStimulus(input pcm_word_t w);
        bit done = 0;
        if (gapMode) begin
            repeat ($urandom_range(0, 2)) begin
                bus.in_valid  = 1'b0;
                bus.dataBusIn = randWord();
                @(posedge clock);
                #1;
            end
        end
        bus.in_valid  = 1'b1;
        bus.dataBusIn = w;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clock);
            done = bus.in_ready;
            @(posedge clock);
            #1;
        end
        if (!done) checkOutput("in_accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic pushRandomHalf();
        for (int k = 0; k < HALF; k++) applyStimulus(randWord());
    endtask

    task automatic pushRampHalf(input logic [15:0] base);
        for (int k = 0; k < HALF; k++)
            applyStimulus({16'(base + 16'd4 + 16'(k)), 16'(base + 16'd3 + 16'(k)),
                           16'(base + 16'd2 + 16'(k)), 16'(base + 16'd1 + 16'(k))});
    endtask

    task automatic drain();
        int t = 0;
        while (expQ.size() != 0 && t < 3000) begin
            @(posedge clock);
            #1;
            t++;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", 0, 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        bus.in_valid  = 1'b0;
        bus.dataBusIn = '0;
`ifdef BLOCK_FRAMER_FLUSH_EN
        bus.flush = 1'b0;
`endif
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        $display("[TB] A/B/C halves, gap-free, always ready");
        pushRampHalf(16'h0000);
        for (int k = 0; k < HALF; k++)
            applyStimulus({16'hFFFF, 16'h8000, 16'(16'h7FFF - 16'(k)), 16'(16'h0100 + 16'(k))});
        for (int k = 0; k < HALF; k++)
            applyStimulus({16'(16'h8000 + 16'(k)), 16'h0000, 16'(16'hFFFF - 16'(k)), 16'h1234});
        drain();

        $display("[TB] 1,0,0 backpressure");
        readyMode = 1;
        pushRandomHalf();
        pushRandomHalf();
        drain();

        $display("[TB] input gaps");
        readyMode = 0;
        gapMode   = 1;
        pushRandomHalf();
        pushRandomHalf();
        drain();

        $display("[TB] random ready with gaps");
        readyMode = 2;
        repeat (3) pushRandomHalf();
        drain();

        $display("[TB] reset during current-half emission");
        gapMode   = 0;
        readyMode = 1;
        pushRandomHalf();
        base = outAccepts;
        for (int t = 0; t < 500 && outAccepts < base + 5; t++) begin
            @(posedge clock);
            #1;
        end
        if (outAccepts < base + 5) checkOutput("mid_emit_timeout", 0, 1);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset     = 1'b1;
        readyMode = 0;
        pushRampHalf(16'h0D00);
        drain();

`ifdef BLOCK_FRAMER_FLUSH_EN
        $display("[TB] flush after two halves");
        pushRampHalf(16'h0A00);
        pushRampHalf(16'h0B00);
        drain();
        bus.flush = 1'b1;
        @(posedge clock);
        #1;
        bus.flush = 1'b0;
        drain();
        pushRampHalf(16'h0E00);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
